hamming_secded_decoder: RTL and testbench

Parametrised serial Hamming decoder with optional SECDED extension. It is the successor to the fixed 7-bit serial decoder. The block shifts in one code bit per enabled cycle and supports any Hamming(2^R−1, 2^R−1−R) code. It corrects single errors, flags double errors when the extra overall-parity bit is enabled, and presents each decoded word on a valid/ready output with a one-entry holding register. It sits between the UART receiver's bit stream and the byte/nibble assembly logic.

---
 rtl/hamming_secded_decoder_if.sv | 37 +++
 rtl/hamming_secded_decoder.sv | 130 +++++++++++++
 tb/tb_hamming_secded_decoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/hamming_secded_decoder_if.sv
// Output bus of the serial Hamming SECDED decoder.
//
// Handshake: the producer (master) raises valid_out when data_out, the error
// flags and syndrome_out hold a decoded word. While valid_out is high and not
// yet accepted, those signals stay stable. The consumer (slave) raises ready_in
// when it can take the word. A transfer happens on every rising clock edge
// where valid_out && ready_in. valid_out never depends combinationally on
// ready_in.
//
// Signals:
//   valid_out          master -> slave  decoded word present
//   ready_in           slave -> master  consumer accepts this cycle
//   data_out[K]        master -> slave  corrected data bits
//   err_corrected      master -> slave  single error was corrected
//   err_uncorrectable  master -> slave  double error detected
//   syndrome_out[R]    master -> slave  syndrome of the held word
interface hamming_secded_decoder_if #(
  parameter int K = 4,
  parameter int R = 3
);
  logic         valid_out;
  logic         ready_in;
  logic [K-1:0] data_out;
  logic         err_corrected;
  logic         err_uncorrectable;
  logic [R-1:0] syndrome_out;

  modport master (
    output valid_out, data_out, err_corrected, err_uncorrectable, syndrome_out,
    input  ready_in
  );

  modport slave (
    input  valid_out, data_out, err_corrected, err_uncorrectable, syndrome_out,
    output ready_in
  );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Serial Hamming(2^R-1, 2^R-1-R) decoder with optional overall-parity (SECDED)
// bit. One code bit is shifted in per ena cycle; the frame is decoded on the
// edge that samples its last bit and lands in a one-entry output register.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   ena              bit strobe; bit_in/sof sampled only when high
//   bit_in           serial code bit
//   sof              start of frame: current bit becomes frame bit 0
//   out_if           decoded-word bus (master side, valid/ready)
//   overrun          one-cycle pulse when a completed frame was dropped
//   debug_count_out  index of the next frame bit to be sampled
module hamming_secded_decoder #(
  parameter int R      = 3,
  parameter int SECDED = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       bit_in,
  input  logic                       sof,
  hamming_secded_decoder_if.master   out_if,
  output logic                       overrun,
  output logic [R-1:0]               debug_count_out
);
  localparam int N = (1 << R) - 1;
  localparam int K = N - R;
  localparam int W = N + ((SECDED != 0) ? 1 : 0);

  logic [R-1:0] count_q;
  logic [W-1:0] buf_q;
  logic [R-1:0] cur_idx;
  logic         last_bit;

  logic [W-1:0] frame;
  logic [N-1:0] fixed;
  logic [R-1:0] syn;
  logic         par;
  logic         flip;
  logic         corr_flag;
  logic         uncorr_flag;
  logic [K-1:0] dec_data;

  // Data bits are the non-power-of-two positions in ascending order.
  function automatic logic [K-1:0] extract_data(input logic [N-1:0] c);
    logic [K-1:0] d;
    int           j;
    d = '0;
    j = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p-1];
        j++;
      end
    end
    return d;
  endfunction

  // sof restarts the frame at the bit being sampled now.
  assign cur_idx  = sof ? '0 : count_q;
  assign last_bit = ena && (cur_idx == R'(W - 1));

  always_comb begin
    // The last bit is not in the buffer yet; merge it in so the decode is
    // ready on the same edge that samples it.
    frame        = buf_q;
    frame[W-1]   = bit_in;
    syn          = '0;
    par          = ^frame;
    flip         = 1'b0;
    corr_flag    = 1'b0;
    uncorr_flag  = 1'b0;
    for (int p = 1; p <= N; p++) begin
      if (frame[p-1]) syn = syn ^ R'(p);
    end
    if (SECDED != 0) begin
      if (syn != '0 && par) begin
        flip      = 1'b1;
        corr_flag = 1'b1;
      end else if (syn == '0 && par) begin
        // Only the overall parity bit was hit; data is intact.
        corr_flag = 1'b1;
      end else if (syn != '0 && !par) begin
        uncorr_flag = 1'b1;
      end
    end else if (syn != '0) begin
      flip      = 1'b1;
      corr_flag = 1'b1;
    end
    fixed = frame[N-1:0];
    for (int p = 1; p <= N; p++) begin
      if (flip && syn == R'(p)) fixed[p-1] = ~fixed[p-1];
    end
    dec_data = extract_data(fixed);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q                  <= '0;
      buf_q                    <= '0;
      out_if.valid_out         <= 1'b0;
      out_if.data_out          <= '0;
      out_if.err_corrected     <= 1'b0;
      out_if.err_uncorrectable <= 1'b0;
      out_if.syndrome_out      <= '0;
      overrun                  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (out_if.valid_out && out_if.ready_in) out_if.valid_out <= 1'b0;
      if (ena) begin
        buf_q[cur_idx] <= bit_in;
        count_q        <= last_bit ? '0 : cur_idx + R'(1);
        if (last_bit) begin
          if (!out_if.valid_out || out_if.ready_in) begin
            out_if.valid_out         <= 1'b1;
            out_if.data_out          <= dec_data;
            out_if.err_corrected     <= corr_flag;
            out_if.err_uncorrectable <= uncorr_flag;
            out_if.syndrome_out      <= syn;
          end else begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

  assign debug_count_out = count_q;
endmodule

// File: tb/tb_hamming_secded_decoder.sv
module tb_hamming_secded_decoder;
  localparam int R = 3;
  localparam int K = 4;

  // Frames as bit vectors, bit 0 arrives first.
  localparam logic [7:0] F_CLEAN   = 8'h55; // data 1011
  localparam logic [7:0] F_FLIP5   = 8'h45; // position 5 flipped
  localparam logic [7:0] F_DBL36   = 8'h71; // positions 3 and 6 flipped
  localparam logic [7:0] F_PAR     = 8'hD5; // overall parity bit flipped
  localparam logic [7:0] F_ONES    = 8'hFF; // data 1111
  localparam logic [7:0] F_ONES_P1 = 8'hFE; // data 1111, position 1 flipped
  localparam logic [7:0] F_ZERO_12 = 8'h03; // data 0000, positions 1 and 2 flipped

  logic         clk;
  logic         rst;
  logic         ena;
  logic         bit_in;
  logic         sof;
  logic         overrun;
  logic [R-1:0] debug_count_out;

  int errors;
  int checks;
  int xfer_count;
  int x0;
  logic [K-1:0] exp_q[$];

  hamming_secded_decoder_if #(.K(K), .R(R)) bus ();

  hamming_secded_decoder #(.R(R), .SECDED(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .ena             (ena),
    .bit_in          (bit_in),
    .sof             (sof),
    .out_if          (bus.master),
    .overrun         (overrun),
    .debug_count_out (debug_count_out)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.valid_out && bus.ready_in) xfer_count <= xfer_count + 1;
  end

  // Driver tasks: inputs change 1 time unit after the edge, outputs are
  // sampled at the same point.
  task automatic send_bit(input logic b, input logic s);
    ena    = 1'b1;
    bit_in = b;
    sof    = s;
    @(posedge clk);
    #1;
    ena    = 1'b0;
    sof    = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f);
    for (int i = 0; i < 8; i++) send_bit(f[i], i == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare the presented word against the oldest expected one.
  task automatic chk_word(input string tag, input logic [R-1:0] syn,
                          input logic ec, input logic eu);
    logic [K-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd1);
    chk({tag, "_data"}, {28'd0, bus.data_out}, {28'd0, e});
    chk({tag, "_syn"}, {29'd0, bus.syndrome_out}, {29'd0, syn});
    chk({tag, "_ec"}, {31'd0, bus.err_corrected}, {31'd0, ec});
    chk({tag, "_eu"}, {31'd0, bus.err_uncorrectable}, {31'd0, eu});
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    xfer_count = 0;
    rst        = 1'b1;
    ena        = 1'b0;
    bit_in     = 1'b0;
    sof        = 1'b0;
    bus.ready_in = 1'b0;
    idle(2);

    // Reset state
    chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("rst_data", {28'd0, bus.data_out}, 32'd0);
    chk("rst_syn", {29'd0, bus.syndrome_out}, 32'd0);
    chk("rst_flags", {30'd0, bus.err_corrected, bus.err_uncorrectable}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_cnt", {29'd0, debug_count_out}, 32'd0);
    rst = 1'b0;
    bus.ready_in = 1'b1;

    // Clean frame, with counter checked mid-frame
    for (int i = 0; i < 3; i++) send_bit(F_CLEAN[i], i == 0);
    chk("cnt_mid", {29'd0, debug_count_out}, 32'd3);
    for (int i = 3; i < 8; i++) send_bit(F_CLEAN[i], 1'b0);
    exp_q.push_back(4'b1011);
    chk_word("clean", 3'b000, 1'b0, 1'b0);
    chk("cnt_wrap", {29'd0, debug_count_out}, 32'd0);
    idle(1);
    chk("clean_drop", {31'd0, bus.valid_out}, 32'd0);

    // Single error at position 5
    send_frame(F_FLIP5);
    exp_q.push_back(4'b1011);
    chk_word("flip5", 3'b101, 1'b1, 1'b0);

    // Double error, positions 3 and 6: raw data
    send_frame(F_DBL36);
    exp_q.push_back(4'b1110);
    chk_word("dbl36", 3'b101, 1'b0, 1'b1);

    // Overall parity bit flipped
    send_frame(F_PAR);
    exp_q.push_back(4'b1011);
    chk_word("par", 3'b000, 1'b1, 1'b0);

    // All-ones word with position 1 flipped
    send_frame(F_ONES_P1);
    exp_q.push_back(4'b1111);
    chk_word("ones_p1", 3'b001, 1'b1, 1'b0);

    // Zero word with positions 1 and 2 flipped
    send_frame(F_ZERO_12);
    exp_q.push_back(4'b0000);
    chk_word("zero12", 3'b011, 1'b0, 1'b1);
    idle(1);

    // Back-pressure: second frame dropped, first word held
    bus.ready_in = 1'b0;
    send_frame(F_CLEAN);
    exp_q.push_back(4'b1011);
    for (int i = 0; i < 4; i++) send_bit(F_ONES[i], i == 0);
    chk("hold_data", {28'd0, bus.data_out}, 32'hB);
    for (int i = 4; i < 8; i++) send_bit(F_ONES[i], 1'b0);
    chk("ovr_pulse", {31'd0, overrun}, 32'd1);
    chk_word("held", 3'b000, 1'b0, 1'b0);
    idle(1);
    chk("ovr_clear", {31'd0, overrun}, 32'd0);
    chk("ovr_valid", {31'd0, bus.valid_out}, 32'd1);
    bus.ready_in = 1'b1;
    x0 = xfer_count;
    idle(1);
    chk("accept_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("accept_xfer", xfer_count - x0, 32'd1);

    // sof at bit 4 discards the partial frame; then a clean frame
    x0 = xfer_count;
    for (int i = 0; i < 4; i++) send_bit(F_CLEAN[i], i == 0);
    send_frame(F_CLEAN);
    exp_q.push_back(4'b1011);
    chk_word("sof4", 3'b000, 1'b0, 1'b0);
    idle(2);
    chk("sof4_xfers", xfer_count - x0, 32'd1);

    // sof on the final bit position restarts the frame, no output
    for (int i = 0; i < 7; i++) send_bit(F_CLEAN[i], i == 0);
    send_bit(F_CLEAN[0], 1'b1);
    chk("sof7_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("sof7_cnt", {29'd0, debug_count_out}, 32'd1);
    for (int i = 1; i < 8; i++) send_bit(F_CLEAN[i], 1'b0);
    exp_q.push_back(4'b1011);
    chk_word("sof7_frame", 3'b000, 1'b0, 1'b0);
    idle(1);

    // Reset mid-frame with a word held
    bus.ready_in = 1'b0;
    send_frame(F_FLIP5);
    for (int i = 0; i < 3; i++) send_bit(F_CLEAN[i], i == 0);
    rst    = 1'b1;
    ena    = 1'b1;
    bit_in = 1'b1;
    idle(1);
    ena = 1'b0;
    chk("mrst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("mrst_data", {28'd0, bus.data_out}, 32'd0);
    chk("mrst_syn", {29'd0, bus.syndrome_out}, 32'd0);
    chk("mrst_flags", {30'd0, bus.err_corrected, bus.err_uncorrectable}, 32'd0);
    chk("mrst_cnt", {29'd0, debug_count_out}, 32'd0);
    rst = 1'b0;
    bus.ready_in = 1'b1;

    // Decoder works normally after reset
    send_frame(F_ONES);
    exp_q.push_back(4'b1111);
    chk_word("post_rst", 3'b000, 1'b0, 1'b0);
    idle(2);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
